axis_stream_fifo: RTL and testbench

- Synchronous single-clock AXI4-Stream FIFO.
- Buffers beats carrying tdata, tkeep, tlast, tid, tdest and tuser.
- Optional store-and-forward (frame) mode.
- Used as the output/elastic buffer in front of the crossbar in the packet-ingress path, e.g. a descriptor beat followed by payload beats.

---
 rtl/axis_stream_fifo.sv | 144 ++++++++++++++
 tb/tb_axis_stream_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_fifo.sv
// Single-clock AXI4-Stream FIFO: WORDS-deep RAM plus one output register,
// with optional store-and-forward mode that drops frames larger than the RAM.
module axis_stream_fifo #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit          LAST_ENABLE = 1'b1,
  parameter bit          ID_ENABLE   = 1'b0,
  parameter int unsigned ID_WIDTH    = 8,
  parameter bit          DEST_ENABLE = 1'b0,
  parameter int unsigned DEST_WIDTH  = 8,
  parameter bit          USER_ENABLE = 1'b1,
  parameter int unsigned USER_WIDTH  = 1,
  parameter bit          FRAME_FIFO  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int unsigned WORDS     = KEEP_ENABLE ? DEPTH / KEEP_WIDTH : DEPTH;
  localparam int unsigned AW        = $clog2(WORDS);
  localparam int unsigned PW        = AW + 1;
  localparam int unsigned OFS_KEEP  = DATA_WIDTH;
  localparam int unsigned OFS_LAST  = OFS_KEEP + KEEP_WIDTH;
  localparam int unsigned OFS_ID    = OFS_LAST + 1;
  localparam int unsigned OFS_DEST  = OFS_ID + ID_WIDTH;
  localparam int unsigned OFS_USER  = OFS_DEST + DEST_WIDTH;
  localparam int unsigned WW        = OFS_USER + USER_WIDTH;

  logic [WW-1:0] mem [WORDS];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          drop_q, drop_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;
  logic [WW-1:0] m_word_q, m_word_d;

  logic          wr_en;
  logic [WW-1:0] s_word;
  logic [PW-1:0] rd_limit;
  logic [PW-1:0] frame_len;

  function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  assign s_word   = {s_axis_tuser, s_axis_tdest, s_axis_tid, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  // In frame mode the reader only sees beats of frames whose tlast was accepted.
  assign rd_limit = FRAME_FIFO ? commit_ptr_q : wr_ptr_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_d       = drop_q;
    m_valid_d    = m_valid_q;
    m_word_d     = m_word_q;
    wr_en        = 1'b0;
    frame_len    = '0;

    if (s_axis_tvalid && s_ready_q) begin
      if (FRAME_FIFO && drop_q) begin
        if (s_axis_tlast) drop_d = 1'b0;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (FRAME_FIFO) begin
          frame_len = wr_ptr_d - commit_ptr_q;
          if (s_axis_tlast) begin
            commit_ptr_d = wr_ptr_d;
          end else if (frame_len == PW'(WORDS)) begin
            // Frame cannot fit even in an empty RAM: rewind and swallow the rest.
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
          end
        end
      end
    end

    if ((rd_ptr_q != rd_limit) && (!m_valid_q || m_axis_tready)) begin
      m_word_d  = mem[rd_ptr_q[AW-1:0]];
      m_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + PW'(1);
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    s_ready_d = (FRAME_FIFO && drop_d) || !ptr_full(wr_ptr_d, rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_word_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_q       <= drop_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_word_q     <= m_word_d;
    end
  end

  // Storage array carries no reset so it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= s_word;
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_word_q[DATA_WIDTH-1:0];
  assign m_axis_tkeep  = KEEP_ENABLE ? m_word_q[OFS_KEEP +: KEEP_WIDTH] : '1;
  assign m_axis_tlast  = LAST_ENABLE ? m_word_q[OFS_LAST] : 1'b1;
  assign m_axis_tid    = ID_ENABLE   ? m_word_q[OFS_ID +: ID_WIDTH] : '0;
  assign m_axis_tdest  = DEST_ENABLE ? m_word_q[OFS_DEST +: DEST_WIDTH] : '0;
  assign m_axis_tuser  = USER_ENABLE ? m_word_q[OFS_USER +: USER_WIDTH] : '0;

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Scoreboard bench for axis_stream_fifo: one plain FIFO and one frame-mode FIFO,
// directed stimulus, queue-based monitors checking every output beat.
module tb_axis_stream_fifo;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [2:0]  dest;
    logic        user;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic        s_tlast;
  logic [7:0]  s_tid;
  logic [2:0]  s_tdest;
  logic        s_tuser;
  logic        s_tvalid, fs_tvalid;
  logic        s_tready, fs_tready;
  logic        m_tready, fm_tready;

  logic [31:0] m_tdata, fm_tdata;
  logic [3:0]  m_tkeep, fm_tkeep;
  logic        m_tvalid, fm_tvalid;
  logic        m_tlast, fm_tlast;
  logic [7:0]  m_tid, fm_tid;
  logic [2:0]  m_tdest, fm_tdest;
  logic        m_tuser, fm_tuser;

  axis_stream_fifo #(
    .DEPTH(16), .DATA_WIDTH(32), .KEEP_WIDTH(4), .DEST_ENABLE(1'b1),
    .DEST_WIDTH(3), .USER_WIDTH(1), .FRAME_FIFO(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser)
  );

  axis_stream_fifo #(
    .DEPTH(16), .DATA_WIDTH(32), .KEEP_WIDTH(4), .DEST_ENABLE(1'b1),
    .DEST_WIDTH(3), .USER_WIDTH(1), .FRAME_FIFO(1'b1)
  ) dut_f (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(fs_tvalid),
    .s_axis_tready(fs_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(fm_tdata), .m_axis_tkeep(fm_tkeep), .m_axis_tvalid(fm_tvalid),
    .m_axis_tready(fm_tready), .m_axis_tlast(fm_tlast), .m_axis_tid(fm_tid),
    .m_axis_tdest(fm_tdest), .m_axis_tuser(fm_tuser)
  );

  int n_tests = 0;
  int n_fail  = 0;
  beat_t exp_q[$];
  beat_t fexp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l,
                               input logic [2:0] dst, input logic u);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.dest = dst; b.user = u;
    return b;
  endfunction

  task automatic set_beat(input beat_t b);
    s_tdata = b.data; s_tkeep = b.keep; s_tlast = b.last; s_tdest = b.dest; s_tuser = b.user;
  endtask

  // Offer one beat and hold it until accepted; tries = cycles spent.
  task automatic drive(input bit frame, input beat_t b, output int tries);
    bit rdy;
    set_beat(b);
    tries = 0;
    rdy   = 1'b0;
    if (frame) fs_tvalid = 1'b1; else s_tvalid = 1'b1;
    while (!rdy && tries < 64) begin
      @(negedge clk);
      rdy = frame ? fs_tready : s_tready;
      @(posedge clk); #1;
      tries++;
    end
    s_tvalid  = 1'b0;
    fs_tvalid = 1'b0;
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: beat 0x%0h never accepted", b);
    end
  endtask

  task automatic wait_drain(input bit frame, input string name);
    int n = 0;
    while ((frame ? fexp_q.size() : exp_q.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(frame ? fexp_q.size() : exp_q.size()), 64'(0));
  endtask

  // Monitors: pop and compare on every output handshake, check stability while stalled.
  beat_t mon_cur, mon_held_beat, fmon_cur, fmon_held_beat, mon_exp, fmon_exp;
  bit    mon_held = 1'b0, fmon_held = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      mon_held = 1'b0;
    end else begin
      mon_cur = {m_tdata, m_tkeep, m_tlast, m_tdest, m_tuser};
      if (mon_held) check("m_stall_hold", 64'({m_tvalid, mon_cur}), 64'({1'b1, mon_held_beat}));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL m_extra_beat: got 0x%0h expected no beat", mon_cur);
        end else begin
          mon_exp = exp_q.pop_front();
          check("m_beat", 64'(mon_cur), 64'(mon_exp));
        end
      end
      mon_held      = m_tvalid && !m_tready;
      mon_held_beat = mon_cur;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      fmon_held = 1'b0;
    end else begin
      fmon_cur = {fm_tdata, fm_tkeep, fm_tlast, fm_tdest, fm_tuser};
      if (fmon_held) check("fm_stall_hold", 64'({fm_tvalid, fmon_cur}), 64'({1'b1, fmon_held_beat}));
      if (fm_tvalid && fm_tready) begin
        if (fexp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL fm_extra_beat: got 0x%0h expected no beat", fmon_cur);
        end else begin
          fmon_exp = fexp_q.pop_front();
          check("fm_beat", 64'(fmon_cur), 64'(fmon_exp));
        end
      end
      fmon_held      = fm_tvalid && !fm_tready;
      fmon_held_beat = fmon_cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int    tries, acc, stalls;
    bit    rdy;
    beat_t b;
    bit    pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b0;
    s_tvalid = 1'b0; fs_tvalid = 1'b0; m_tready = 1'b0; fm_tready = 1'b0;
    s_tid = 8'h5A;
    set_beat(mk(32'h0, 4'h0, 1'b0, 3'd0, 1'b0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_fs_tready", 64'(fs_tready), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s_tready", 64'(s_tready), 64'(1));
    check("post_rst_fs_tready", 64'(fs_tready), 64'(1));

    // 1: single beat, one-cycle latency
    m_tready = 1'b1;
    b = mk(32'hA5A5_0001, 4'hF, 1'b1, 3'd3, 1'b1);
    exp_q.push_back(b);
    drive(1'b0, b, tries);
    check("t1_valid_edge_n", 64'(m_tvalid), 64'(0));
    @(posedge clk); #1;
    check("t1_valid_edge_n1", 64'(m_tvalid), 64'(1));
    check("t1_beat", 64'({m_tdata, m_tkeep, m_tlast, m_tdest, m_tuser}), 64'(b));
    check("t1_tid_disabled", 64'(m_tid), 64'(0));
    @(posedge clk); #1;
    check("t1_valid_edge_n2", 64'(m_tvalid), 64'(0));

    // 2: fill with output stalled; capacity is RAM words plus the output register
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'(i), 4'hF, i == 7, 3'(i), 1'(i)));
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      set_beat(mk(32'(acc), 4'hF, acc == 7, 3'(acc), 1'(acc)));
      s_tvalid = 1'b1;
      @(negedge clk);
      rdy = s_tready;
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    check("t2_accepted", 64'(acc), 64'(5));
    check("t2_tready_low", 64'(s_tready), 64'(0));
    check("t2_head", 64'(m_tdata), 64'(0));
    m_tready = 1'b1;
    for (int i = 5; i < 8; i++) drive(1'b0, mk(32'(i), 4'hF, i == 7, 3'(i), 1'(i)), tries);
    wait_drain(1'b0, "t2_drain");

    // 3: backpressure on a 3-beat frame
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = mk(32'h3000_0000 + 32'(i), (i == 2) ? 4'h1 : 4'hF, i == 2, 3'd0, 1'b0);
      exp_q.push_back(b);
      drive(1'b0, b, tries);
    end
    for (int c = 0; c < 8; c++) begin
      m_tready = pat[c];
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    wait_drain(1'b0, "t3_drain");

    // 4: 100-beat streaming at full rate
    for (int i = 0; i < 100; i++) exp_q.push_back(mk(32'(i), 4'hF, i == 99, 3'(i), 1'(i)));
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, mk(32'(i), 4'hF, i == 99, 3'(i), 1'(i)), tries);
      if (tries > 1) stalls++;
    end
    check("t4_input_stalls", 64'(stalls), 64'(0));
    @(posedge clk); #1;
    check("t4_last_out", 64'({m_tvalid, m_tdata, m_tlast}), 64'({1'b1, 32'd99, 1'b1}));
    check("t4_backlog", 64'(exp_q.size()), 64'(1));
    wait_drain(1'b0, "t4_drain");

    // 5: asynchronous reset while beats are buffered
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, mk(32'hB0 + 32'(i), 4'hF, i == 2, 3'd1, 1'b0), tries);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("t5_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("t5_rst_s_tready", 64'(s_tready), 64'(0));
    m_tready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_empty_after_rst", 64'(m_tvalid), 64'(0));
    check("t5_tready_after_rst", 64'(s_tready), 64'(1));
    b = mk(32'h1234, 4'hF, 1'b1, 3'd2, 1'b1);
    exp_q.push_back(b);
    drive(1'b0, b, tries);
    wait_drain(1'b0, "t5_drain");
    repeat (4) @(posedge clk);
    #1;

    // 6: store-and-forward mode
    fm_tready = 1'b1;
    for (int i = 0; i < 3; i++) fexp_q.push_back(mk(32'hF000 + 32'(i), 4'hF, i == 2, 3'd4, 1'(i)));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(32'hF000 + 32'(i), 4'hF, i == 2, 3'd4, 1'(i)), tries);
      check("t6_no_early_out", 64'(fm_tvalid), 64'(0));
    end
    @(posedge clk); #1;
    check("t6_commit_out", 64'(fm_tvalid), 64'(1));
    check("t6_tid_disabled", 64'(fm_tid), 64'(0));
    wait_drain(1'b1, "t6_frame_a_drain");
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, mk(32'hD000 + 32'(i), 4'hF, i == 5, 3'd5, 1'b0), tries);
      if (tries > 1) stalls++;
    end
    check("t6_oversize_accept", 64'(stalls), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    check("t6_oversize_dropped", 64'(fm_tvalid), 64'(0));
    for (int i = 0; i < 2; i++) fexp_q.push_back(mk(32'hC000 + 32'(i), 4'h7, i == 1, 3'd6, 1'b1));
    for (int i = 0; i < 2; i++) drive(1'b1, mk(32'hC000 + 32'(i), 4'h7, i == 1, 3'd6, 1'b1), tries);
    wait_drain(1'b1, "t6_frame_c_drain");

    repeat (5) @(posedge clk);
    #1;
    check("final_q_empty", 64'(exp_q.size()), 64'(0));
    check("final_fq_empty", 64'(fexp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
